// File: rtl/track_pkg.sv
// rtl/track_pkg.sv - shared state encoding and size defaults for the track position controller
package track_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOMING = 2'd1,
        ST_MOVING = 2'd2
    } state_t;

    localparam int TRACK_POS_W   = 12;
    localparam int TRACK_MAX_POS = 2000;

endpackage

// File: rtl/track_position_ctrl_if.sv
// rtl/track_position_ctrl_if.sv - absolute position command handshake
interface track_position_ctrl_if
    import track_pkg::*;
#(
    parameter int POS_W = TRACK_POS_W
);

    logic             cmd_valid;
    logic [POS_W-1:0] cmd_target;
    logic             cmd_ready;

    modport master (output cmd_valid, output cmd_target, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_target, output cmd_ready);

endinterface

// File: rtl/track_tick_gen.sv
// rtl/track_tick_gen.sv - step period counter with synchronous restart
module track_tick_gen #(
    parameter int PERIOD = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (restart || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/track_position_ctrl.sv
// rtl/track_position_ctrl.sv - position command stage, step counter and homing for track_driver
module track_position_ctrl
    import track_pkg::*;
#(
    parameter int DEFINE_SPEED = 10,
    parameter int CLK_PER_MS   = 50000,
    parameter int POS_W        = TRACK_POS_W,
    parameter int MAX_POS      = TRACK_MAX_POS,
    parameter int HOME_MARGIN  = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    track_position_ctrl_if.slave  cmd,
    input  logic                  home_req,
    input  logic                  home_sw,
    input  logic                  abort_i,
    output logic                  move_o,
    output logic                  back_o,
    output logic [POS_W-1:0]      pos_o,
    output logic                  homed_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int HOME_LIMIT = MAX_POS + HOME_MARGIN;
    localparam int SC_W       = $clog2(HOME_LIMIT + 1);
    localparam logic [POS_W-1:0] MAX_POS_V = POS_W'(MAX_POS);
    localparam logic [SC_W-1:0]  STEP_LAST = SC_W'(HOME_LIMIT - 1);

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d, target_q, target_d;
    logic [SC_W-1:0]  steps_q, steps_d;
    logic             homed_q, homed_d, done_q, done_d, err_q, err_d;
    logic             sync1_q, sync2_q, sw_q;
    logic [3:0]       sw_hist_q, sw_hist_next;
    logic             tick, restart, cmd_fire, toward_home;

    track_tick_gen #(
        .PERIOD (DEFINE_SPEED * CLK_PER_MS)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // The switch only counts as changed after four equal samples taken one step period apart.
    assign sw_hist_next = {sw_hist_q[2:0], sync2_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sw_hist_q <= 4'b0000;
            sw_q      <= 1'b0;
        end else begin
            sync1_q <= home_sw;
            sync2_q <= sync1_q;
            if (tick) begin
                sw_hist_q <= sw_hist_next;
                if (&sw_hist_next) begin
                    sw_q <= 1'b1;
                end else if (~|sw_hist_next) begin
                    sw_q <= 1'b0;
                end
            end
        end
    end

    // Holding off ready while homing or aborting keeps a competing command pending.
    assign cmd.cmd_ready = (state_q == ST_IDLE) && !home_req && !abort_i;
    assign cmd_fire      = cmd.cmd_valid && cmd.cmd_ready;
    assign toward_home   = (target_q < pos_q);
    assign restart       = (state_q == ST_IDLE) && (state_d != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        target_d = target_q;
        steps_d  = steps_q;
        homed_d  = homed_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (home_req) begin
                        state_d = ST_HOMING;
                        homed_d = 1'b0;
                        steps_d = '0;
                    end else if (cmd_fire) begin
                        if (!homed_q || (cmd.cmd_target > MAX_POS_V)) begin
                            err_d = 1'b1;
                        end else if (cmd.cmd_target == pos_q) begin
                            done_d = 1'b1;
                        end else begin
                            target_d = cmd.cmd_target;
                            state_d  = ST_MOVING;
                        end
                    end
                end
                ST_HOMING: begin
                    if (sw_q) begin
                        pos_d   = '0;
                        homed_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (tick) begin
                        if (steps_q == STEP_LAST) begin
                            err_d   = 1'b1;
                            homed_d = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            steps_d = steps_q + 1'b1;
                        end
                    end
                end
                ST_MOVING: begin
                    if (tick) begin
                        pos_d = toward_home ? (pos_q - 1'b1) : (pos_q + 1'b1);
                        if (pos_d == target_q) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pos_q    <= '0;
            target_q <= '0;
            steps_q  <= '0;
            homed_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            target_q <= target_d;
            steps_q  <= steps_d;
            homed_q  <= homed_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign move_o  = (state_q != ST_IDLE);
    assign busy_o  = (state_q != ST_IDLE);
    assign back_o  = (state_q == ST_HOMING) || ((state_q == ST_MOVING) && toward_home);
    assign pos_o   = pos_q;
    assign homed_o = homed_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule
